// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types for the ALU execute stage.
// The ALU opcode enum is the same one the upstream datapath uses for its
// ALUCtrl field, so both sides agree on the encodings.
// Optional feature macro: ALU_EXEC_OVF_EN adds a signed-overflow flag to
// the buffered result record.
package alu_exec_pkg;

    // Operand/result width.
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Number of results currently held (output register + skid register).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              illegal;
`ifdef ALU_EXEC_OVF_EN
        logic              ovf;
`endif
    } alu_res_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: valid/ready bus around the ALU execute stage.
//   in_valid/in_ready/alu_ctrl/op_a/op_b : upstream operation handshake
//   out_valid/out_ready/result/zero/illegal : downstream result handshake
//   ovf : signed overflow flag (only with ALU_EXEC_OVF_EN defined)
// Modports: master = producer/consumer side (bench or neighbouring stages),
//           slave  = the execute stage itself.
interface alu_exec_stage_if;
    import alu_exec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
`ifdef ALU_EXEC_OVF_EN
    logic              ovf;
`endif

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
`ifdef ALU_EXEC_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
`ifdef ALU_EXEC_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU.
//   i_alu_ctrl : 3-bit ALUCtrl code
//   i_op_a/b   : operands
//   o_res      : result record (result, zero, illegal[, ovf])
// Undefined codes (011/100/101) give result 0 with illegal set.
// Optional feature macro: ALU_EXEC_OVF_EN (signed overflow for ADD/SUB).
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [2:0]        i_alu_ctrl,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output alu_res_t          o_res
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_illegal;

    // Carry/borrow out is dropped: both wrap modulo 2^DATA_W.
    assign w_sum  = i_op_a + i_op_b;
    assign w_diff = i_op_a - i_op_b;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (i_alu_ctrl)
            ALU_AND: w_result = i_op_a & i_op_b;
            ALU_OR:  w_result = i_op_a | i_op_b;
            ALU_ADD: w_result = w_sum;
            ALU_SUB: w_result = w_diff;
            ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            default: w_illegal = 1'b1;
        endcase
    end

    assign o_res.result  = w_result;
    assign o_res.zero    = (w_result == '0);
    assign o_res.illegal = w_illegal;

`ifdef ALU_EXEC_OVF_EN
    logic w_ovf;

    // ADD overflows when both operands share a sign the sum does not;
    // SUB overflows when the operands differ in sign and the difference
    // takes the sign of op_b instead of op_a.
    always_comb begin
        w_ovf = 1'b0;
        case (i_alu_ctrl)
            ALU_ADD: w_ovf = (i_op_a[DATA_W-1] == i_op_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1]  != i_op_a[DATA_W-1]);
            ALU_SUB: w_ovf = (i_op_a[DATA_W-1] != i_op_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != i_op_a[DATA_W-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    assign o_res.ovf = w_ovf;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a two-entry buffer.
//   clk   : stage clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, synchronous release upstream
//   bus   : alu_exec_stage_if.slave (operation in, result out, valid/ready)
// The output register plus a skid register let the stage accept one op per
// cycle under backpressure while in_ready comes straight from a flop.
// Optional feature macro: ALU_EXEC_OVF_EN adds bus.ovf.
module alu_exec_stage
    import alu_exec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_stage_if.slave      bus
);

    buf_state_e r_state;
    buf_state_e w_state_next;
    alu_res_t   r_out;
    alu_res_t   w_out_next;
    alu_res_t   r_skid;
    alu_res_t   w_skid_next;
    alu_res_t   w_core_res;
    logic       r_in_ready;
    logic       w_in_ready_next;
    logic       w_out_valid;
    logic       w_in_xfer;
    logic       w_out_xfer;

    alu_core u_alu_core (
        .i_alu_ctrl (bus.alu_ctrl),
        .i_op_a     (bus.op_a),
        .i_op_b     (bus.op_b),
        .o_res      (w_core_res)
    );

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_xfer   = bus.in_valid & r_in_ready;
    assign w_out_xfer  = w_out_valid & bus.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_skid_next  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_next = ONE;
                    w_out_next   = w_core_res;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_out_next   = w_core_res;
                end else if (w_in_xfer) begin
                    w_state_next = TWO;
                    w_skid_next  = w_core_res;
                end else if (w_out_xfer) begin
                    w_state_next = EMPTY;
                end
            end
            TWO: begin
                // No input transfer is possible here (in_ready is low).
                if (w_out_xfer) begin
                    w_state_next = ONE;
                    w_out_next   = r_skid;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
        // Registering the next-state decode keeps in_ready free of any
        // combinational path from out_ready.
        w_in_ready_next = (w_state_next != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_out      <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_out      <= w_out_next;
            r_skid     <= w_skid_next;
            r_in_ready <= w_in_ready_next;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_out.result;
    assign bus.zero      = r_out.zero;
    assign bus.illegal   = r_out.illegal;
`ifdef ALU_EXEC_OVF_EN
    assign bus.ovf       = r_out.ovf;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: self-checking bench for alu_exec_stage.
// A queue-based reference model holds the results the stage should be
// buffering; ALU results are computed with plain wide signed arithmetic.
module tb_alu_exec_stage;
    import alu_exec_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    alu_exec_stage_if bus();

    alu_exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_op(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (c)
            3'd0: e.result = a & b;
            3'd1: e.result = a | b;
            3'd2: begin
                wide     = sa + sb;
                e.result = wide[31:0];
                e.ovf    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd6: begin
                wide     = sa - sb;
                e.result = wide[31:0];
                e.ovf    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd7: e.result = (sa < sb) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // Advance one clock edge and update the model with what that edge does.
    task automatic tick();
        bit acc;
        bit pop;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            acc = bus.in_valid && (exp_q.size() < 2);
            pop = bus.out_ready && (exp_q.size() > 0);
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(ref_op(bus.alu_ctrl, bus.op_a, bus.op_b));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'd5, 32'd7);
        #2;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid_async: got %b expected 0", bus.out_valid); end
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        n_checks++; if (bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got zero=%b illegal=%b expected 0 0", bus.zero, bus.illegal); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd12) begin n_errors++; $display("FAIL reset_first_op: got valid=%b result=%h expected 1 0000000c", bus.out_valid, bus.result); end
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ctl [5];
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [31:0] r [5];
        logic        z [5];
        ctl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        a   = '{32'd5, 32'd3, 32'hF0, 32'hF0, 32'hFFFF_FFFF};
        b   = '{32'd7, 32'd3, 32'h3C, 32'h0F, 32'd1};
        r   = '{32'd12, 32'd0, 32'h30, 32'hFF, 32'd1};
        z   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(1'b1, ctl[i], a[i], b[i]);
            else       drive(1'b0, 3'b000, 32'd0, 32'd0);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            if (i == 0) begin
                n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got %b expected 0", bus.out_valid); end
            end else begin
                n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
                n_checks++; if (bus.result !== r[i-1] || bus.zero !== z[i-1]) begin n_errors++; $display("FAIL b2b_result[%0d]: got %h zero=%b expected %h zero=%b", i, bus.result, bus.zero, r[i-1], z[i-1]); end
            end
            tick();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_no_dup: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic        iv  [8];
        logic [31:0] val [8];
        logic        ordy[8];
        logic        eir [8];
        logic        eov [8];
        logic [31:0] eres[8];
        iv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        val  = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3, 32'd0, 32'd0};
        ordy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eir  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        eov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eres = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd0};
        for (int i = 0; i < 8; i++) begin
            drive(iv[i], 3'b010, val[i], 32'd0);
            bus.out_ready = ordy[i];
            n_checks++; if (bus.in_ready !== eir[i]) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, bus.in_ready, eir[i]); end
            n_checks++; if (bus.out_valid !== eov[i]) begin n_errors++; $display("FAIL bp_out_valid[%0d]: got %b expected %b", i, bus.out_valid, eov[i]); end
            if (eov[i]) begin
                n_checks++; if (bus.result !== eres[i]) begin n_errors++; $display("FAIL bp_result[%0d]: got %h expected %h", i, bus.result, eres[i]); end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [2:0] codes [3];
        codes = '{3'b011, 3'b100, 3'b101};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, codes[i], 32'd9, 32'd9);
            tick();
            drive(1'b0, 3'b000, 32'd0, 32'd0);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.illegal !== 1'b1) begin
                n_errors++; $display("FAIL illegal_%b: got valid=%b result=%h zero=%b illegal=%b expected 1 00000000 1 1", codes[i], bus.out_valid, bus.result, bus.zero, bus.illegal);
            end
            tick();
        end
    endtask

`ifdef ALU_EXEC_OVF_EN
    task automatic test_ovf();
        logic [2:0]  ctl [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] r [3];
        logic        o [3];
        ctl = '{3'b010, 3'b110, 3'b010};
        a   = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1};
        b   = '{32'd1, 32'd1, 32'd1};
        r   = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        o   = '{1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ctl[i], a[i], b[i]);
            tick();
            drive(1'b0, 3'b000, 32'd0, 32'd0);
            n_checks++; if (bus.result !== r[i] || bus.ovf !== o[i]) begin n_errors++; $display("FAIL ovf[%0d]: got %h ovf=%b expected %h ovf=%b", i, bus.result, bus.ovf, r[i], o[i]); end
            tick();
        end
    endtask
`endif

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        bit pending;
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                if ($urandom_range(0, 9) < 7) drive(1'b1, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
                else                          drive(1'b0, 3'b000, 32'd0, 32'd0);
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
            n_checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin n_errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_q.size() < 2); end
            n_checks++; if (bus.out_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                n_checks++; if (bus.result !== exp_q[0].result || bus.zero !== exp_q[0].zero || bus.illegal !== exp_q[0].illegal) begin
                    n_errors++; $display("FAIL rand_result[%0d]: got %h z=%b il=%b expected %h z=%b il=%b", i, bus.result, bus.zero, bus.illegal, exp_q[0].result, exp_q[0].zero, exp_q[0].illegal);
                end
`ifdef ALU_EXEC_OVF_EN
                n_checks++; if (bus.ovf !== exp_q[0].ovf) begin n_errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, bus.ovf, exp_q[0].ovf); end
`endif
            end
            pending = bus.in_valid && (exp_q.size() >= 2);
            tick();
        end
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_in_two();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h11, 32'd0);
        tick();
        drive(1'b1, 3'b010, 32'h22, 32'd0);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL two_state: got in_ready=%b out_valid=%b expected 0 1", bus.in_ready, bus.out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'd0) begin
            n_errors++; $display("FAIL two_async_reset: got out_valid=%b in_ready=%b result=%h expected 0 1 00000000", bus.out_valid, bus.in_ready, bus.result);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL two_stale[%0d]: got %b expected 0", i, bus.out_valid); end
            tick();
        end
        drive(1'b1, 3'b010, 32'h33, 32'd0);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h33) begin n_errors++; $display("FAIL two_after_reset: got valid=%b result=%h expected 1 00000033", bus.out_valid, bus.result); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL two_after_drain: got %b expected 0", bus.out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_illegal();
`ifdef ALU_EXEC_OVF_EN
        test_ovf();
`endif
        test_random();
        test_reset_in_two();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of datapathV2; consumes its 3-bit ALUCtrl plus two operands, computes the ALU result and registers it.
- Valid/ready handshake on both sides.
- Two-entry buffer (output register plus skid register) so in_ready is a pure register output and full throughput holds under backpressure.
- Feeds the memory/writeback stage.

Parameters:
- DATA_W, 32, operand/result width.

Ports:
- clk  input  1  stage clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents op/operands.
- in_ready  output  1  stage can accept this cycle.
- alu_ctrl  input  3  ALUCtrl from datapathV2.
- op_a  input  DATA_W  operand A.
- op_b  input  DATA_W  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts.
- result  output  DATA_W  ALU result.
- zero  output  1  result == 0.
- illegal  output  1  alu_ctrl was an undefined code.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, in_ready=1, result=0, zero=0, illegal=0.
  - Skid entry cleared; state EMPTY.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Inputs are sampled only on an input transfer.
- Decode (combinational on the input side, registered into the buffer):
  - 000 AND; 001 OR; 010 ADD; 110 SUB.
  - 111 SLT: signed compare, result = {DATA_W-1 zeros, a<b}.
  - 011/100/101: result 0, illegal=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W; carry out is discarded.
  - zero is computed from the stored result, never from a stale value.
- Latency: one cycle. An input accepted on edge N appears on out_* after edge N with out_valid=1.
- States (count of buffered results):
  - EMPTY:
    - in_valid → ONE (result to output register).
  - ONE:
    - input transfer and output transfer together → ONE; new result replaces the output register.
    - input transfer only → TWO; new result goes to skid.
    - output transfer only → EMPTY.
    - neither → hold.
  - TWO:
    - in_ready=0.
    - output transfer → ONE; skid moves into the output register.
    - no output transfer → hold.
- in_ready = (state != TWO), driven from a register and never combinationally dependent on out_ready.
- Ordering: results leave strictly in acceptance order; no loss or duplication under any valid/ready pattern.
- out_* stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all buffered results are discarded and the stage returns to EMPTY immediately, regardless of state.

Optional Feature:
- Macro ALU_EXEC_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), buffered alongside result.
  - ovf=1 on signed overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from op_a).
  - ovf=0 for all other ops; reset value 0.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package alu_exec_pkg:
  - typedef alu_op_e, 3-bit enum: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - typedef buf_state_e: EMPTY, ONE, TWO.
  - typedef alu_res_t: struct {result, zero, illegal[, ovf]}.
  - Shared with datapathV2 so its ALUCtrl encodings come from the same enum.
- Sub-module alu_core: purely combinational op/operands → alu_res_t.
- alu_exec_stage holds the handshake FSM and both buffer registers.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, in_ready=1, result=0 during reset; first op accepted on first edge after release.
- out_ready=1, ops ADD 5+7, SUB 3-3, AND F0&3C, OR F0|0F, SLT -1<1 back-to-back → one result/cycle, 1 cycle latency:
  - 12 (zero=0), 0 (zero=1), 30, FF, 1.
- out_ready=0 while 3 ops offered:
  - First two accepted; in_ready=0 from the cycle after the second; third held by upstream.
  - Release out_ready → results drain in order 1,2,3 with no gap and no loss.
- alu_ctrl=100, op_a=9, op_b=9 → result=0, zero=1, illegal=1.
- With ALU_EXEC_OVF_EN:
  - ADD 7FFFFFFF+1 → result 80000000, ovf=1.
  - SUB 80000000-1 → 7FFFFFFF, ovf=1.
  - ADD 1+1 → ovf=0.
- Assert rst_n low while in state TWO → out_valid=0 and in_ready=1 asynchronously; no stale result emitted after release.
